alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single-cycle combinational execute-stage ALU between two requesters, for example the EXE pipeline stage and an address/auxiliary unit. It uses round-robin arbitration and a valid/ready handshake. Operands are captured into an internal register stage, and the ALU result and flags are registered. The block also owns the architectural status register {Z,C,N,V} and supplies its C bit to the ALU for ADC/SBC.

## Interface
- WIDTH, 32, datapath width of operands and result
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle
- req0_cmd / req1_cmd  in  4  ALU command (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000)
- req0_val1 / req1_val1, req0_val2 / req1_val2  in  WIDTH  operands
- req0_s / req1_s  in  1  update the status register with this result's flags
- alu_cmd  out  4  to the ALU, from captured registers
- alu_val1 / alu_val2  out  WIDTH  to the ALU
- alu_c  out  1  to the ALU; always equals sr_q[2]
- alu_out  in  WIDTH  from the ALU
- alu_sr  in  4  from the ALU, ordered {Z,C,N,V}
- resp0_valid / resp1_valid  out  1  result for requester N is available
- resp0_ready / resp1_ready  in  1  requester N consumes the result
- resp_result  out  WIDTH  registered result (shared by both requesters)
- resp_sr  out  4  registered flags of that result
- sr_q  out  4  status register {Z,C,N,V}

## Operation
- FSM states:
  - IDLE:
    - If any reqN_valid is high, grant one requester.
    - With both valid, grant the requester other than last_grant.
    - With one valid, grant that requester.
    - Assert the granted reqN_ready combinationally in the same cycle.
    - On the clock edge, capture cmd, val1, val2, s and the grant id, then go to EXEC.
  - EXEC:
    - Drive alu_cmd, alu_val1 and alu_val2 from the captured registers.
    - On the clock edge, register alu_out into resp_result and alu_sr into resp_sr.
    - If the captured s is 1, load sr_q with alu_sr.
    - Update last_grant to the grant id, then go to RESP.
  - RESP:
    - Hold respN_valid high for the granted requester only, with resp_result and resp_sr stable.
    - When respN_ready is 1, return to IDLE on that edge.
- reqN_ready is 0 in EXEC and RESP. A requester must hold valid and its payload stable until it is accepted.
- alu_c is sampled from sr_q as it stands at EXEC. A flag update from operation k is therefore visible to the ADC/SBC of operation k+1.
- No new request is accepted during RESP. There is exactly one transaction in flight.
- Result and flags come only from the ALU. This block performs no arithmetic of its own.
- Reset (asynchronous, at any time, including mid-EXEC or mid-RESP):
  - State returns to IDLE and the in-flight transaction is discarded. No response is produced for it.
  - sr_q = 0000, resp_result = 0, resp_sr = 0000.
  - last_grant = 1, so requester 0 wins the first contention.
  - All captured registers are cleared to 0. alu_* outputs are therefore 0, and alu_c = 0.
  - reqN_ready follows IDLE arbitration as soon as reset deasserts.
  - respN_valid = 0.

## Timing
- Accept in cycle T (valid & ready): ALU evaluated in T+1, respN_valid first high in T+2.
- Minimum issue interval is 3 cycles when respN_ready is held high.
- sr_q changes at the end of T+1, when s is 1.
- resp_result, resp_sr and sr_q hold their values until the next EXEC edge or reset.
- Back-pressure: respN_ready low keeps the FSM in RESP indefinitely. Both requesters stall.
- Simultaneous validity: in each IDLE cycle the grant alternates, so neither requester waits more than one transaction while the other is valid.
- In the cycle the FSM enters IDLE from RESP, a waiting request is accepted immediately (T+3 after the previous accept).

## Test plan
- After reset:
  - Stimulus: req0 ADD 5+3, s=1.
  - Required: req0_ready high in the first cycle; resp0_valid two cycles later with resp_result=0x00000008, resp_sr=0000, sr_q=0000; resp1_valid never asserts.
- Zero-result flag update:
  - Stimulus: req1 SUB 7-7, s=1.
  - Required: resp_result=0, resp_sr=1000, sr_q=1000.
  - Stimulus: a following req1 AND 0xF0 & 0x0F with s=0.
  - Required: result 0, and sr_q remains 1000.
- Carry chaining:
  - Stimulus: req0 ADD 0xFFFFFFFF+1, s=1.
  - Required: resp_result 0 and sr_q[2] set to the ALU's carry-out.
  - Stimulus: req1 ADC 1+1.
  - Required: alu_c equals sr_q[2], and resp_result = 2 + alu_c.
- Contention:
  - Stimulus: both valid continuously, resp ready tied high.
  - Required: grants go 0,1,0,1 with accepts every 3 cycles; each respN_valid matches its requester's operands.
- Back-pressure:
  - Stimulus: hold resp0_ready low 5 cycles with req1 valid.
  - Required: resp0_valid and resp_result stable for the 5 cycles, req1_ready low, req1 accepted on the cycle after resp0_ready rises.
- Reset during EXEC and during RESP:
  - Required: all outputs at reset values immediately, no respN_valid for the dropped operation, and the next accepted request completes normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// One transaction in flight: IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_val1,
  input  logic [WIDTH-1:0] req0_val2,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_val1,
  input  logic [WIDTH-1:0] req1_val2,
  input  logic             req1_s,
  output logic [3:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_val1,
  output logic [WIDTH-1:0] alu_val2,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_sr,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_sr,
  output logic [3:0]       sr_q
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               gid_q, gid_d;
  logic               s_q, s_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   val1_q, val1_d;
  logic [WIDTH-1:0]   val2_q, val2_d;
  logic [WIDTH-1:0]   resp_result_q, resp_result_d;
  logic [3:0]         resp_sr_q, resp_sr_d;
  logic [3:0]         sr_d;
  logic               grant0, grant1;

  // Under contention the requester that did not win last time gets the grant.
  assign grant0 = req0_valid & (~req1_valid |  last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready  = (state_q == IDLE) & grant0;
  assign req1_ready  = (state_q == IDLE) & grant1;
  assign resp0_valid = (state_q == RESP) & ~gid_q;
  assign resp1_valid = (state_q == RESP) &  gid_q;

  assign alu_cmd     = cmd_q;
  assign alu_val1    = val1_q;
  assign alu_val2    = val2_q;
  assign alu_c       = sr_q[2];
  assign resp_result = resp_result_q;
  assign resp_sr     = resp_sr_q;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gid_d         = gid_q;
    s_d           = s_q;
    cmd_d         = cmd_q;
    val1_d        = val1_q;
    val2_d        = val2_q;
    resp_result_d = resp_result_q;
    resp_sr_d     = resp_sr_q;
    sr_d          = sr_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          gid_d   = grant1;
          cmd_d   = grant1 ? req1_cmd  : req0_cmd;
          val1_d  = grant1 ? req1_val1 : req0_val1;
          val2_d  = grant1 ? req1_val2 : req0_val2;
          s_d     = grant1 ? req1_s    : req0_s;
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp_result_d = alu_out;
        resp_sr_d     = alu_sr;
        if (s_q) sr_d = alu_sr;
        last_grant_d  = gid_q;
        state_d       = RESP;
      end
      RESP: begin
        if (gid_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      gid_q         <= 1'b0;
      s_q           <= 1'b0;
      cmd_q         <= '0;
      val1_q        <= '0;
      val2_q        <= '0;
      resp_result_q <= '0;
      resp_sr_q     <= '0;
      sr_q          <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gid_q         <= gid_d;
      s_q           <= s_d;
      cmd_q         <= cmd_d;
      val1_q        <= val1_d;
      val2_q        <= val2_d;
      resp_result_q <= resp_result_d;
      resp_sr_q     <= resp_sr_d;
      sr_q          <= sr_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table plus contention, back-pressure and reset sequences.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_cmd, req1_cmd;
  logic [31:0] req0_val1, req0_val2, req1_val1, req1_val2;
  logic        req0_s, req1_s;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_val1, alu_val2, alu_out;
  logic        alu_c;
  logic [3:0]  alu_sr;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic [3:0]  resp_sr, sr_q;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_s(req1_s),
    .alu_cmd(alu_cmd), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_c(alu_c),
    .alu_out(alu_out), .alu_sr(alu_sr),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_sr(resp_sr), .sr_q(sr_q)
  );

  localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011,
                         SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                         EOR = 4'b1000;

  // Reference ALU: flags {Z,C,N,V}; C is carry-out on add, borrow on subtract.
  function automatic logic [35:0] alu_f(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    logic [32:0] r;
    logic cf, vf;
    r = '0; cf = 1'b0; vf = 1'b0;
    case (cmd)
      MOV: r = {1'b0, b};
      MVN: r = {1'b0, ~b};
      ADD, ADC: begin
        r  = {1'b0, a} + {1'b0, b} + ((cmd == ADC) ? {32'd0, c} : 33'd0);
        cf = r[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, SBC: begin
        r  = {1'b0, a} - {1'b0, b} - ((cmd == SBC) ? {32'd0, c} : 33'd0);
        cf = r[32];
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AND: r = {1'b0, a & b};
      ORR: r = {1'b0, a | b};
      EOR: r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return {(r[31:0] == 32'd0), cf, r[31], vf, r[31:0]};
  endfunction

  always_comb {alu_sr, alu_out} = alu_f(alu_cmd, alu_val1, alu_val2, alu_c);

  typedef struct {
    logic        id;
    logic [3:0]  cmd;
    logic [31:0] v1, v2;
    logic        s;
    logic [31:0] res;
    logic [3:0]  sr, srq;
    logic        c;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [3:0]  sr;
  } sb_t;

  sb_t sb[$];
  int  nvec = 0;
  int  nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [3:0] cmd,
                         input logic [31:0] a, input logic [31:0] b, input logic s);
    if (id) begin
      req1_valid = v; req1_cmd = cmd; req1_val1 = a; req1_val2 = b; req1_s = s;
    end else begin
      req0_valid = v; req0_cmd = cmd; req0_val1 = a; req0_val2 = b; req0_s = s;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Called at posedge+1 with the FSM in IDLE; leaves the FSM back in IDLE.
  task automatic do_op(input vec_t v);
    sb_t e;
    int n;
    set_req(v.id, 1'b1, v.cmd, v.v1, v.v2, v.s);
    #1;
    n = 0;
    while (!rdy(v.id) && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready", 32'(rdy(v.id)), 32'd1);
    chk("other_ready", 32'(rdy(~v.id)), 32'd0);
    sb.push_back('{id: v.id, res: v.res, sr: v.sr});
    @(posedge clk); #1;
    set_req(v.id, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("exec_alu_cmd", 32'(alu_cmd), 32'(v.cmd));
    chk("exec_alu_val1", alu_val1, v.v1);
    chk("exec_alu_val2", alu_val2, v.v2);
    chk("exec_alu_c", 32'(alu_c), 32'(v.c));
    chk("exec_no_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid_mine", 32'(v.id ? resp1_valid : resp0_valid), 32'd1);
    chk("resp_valid_other", 32'(v.id ? resp0_valid : resp1_valid), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_result", resp_result, e.res);
      chk("resp_sr", 32'(resp_sr), 32'(e.sr));
    end else chk("sb_empty", 32'd0, 32'd1);
    chk("sr_q", 32'(sr_q), 32'(v.srq));
    @(posedge clk); #1;
  endtask

  vec_t tbl[11];

  initial begin
    sb_t e;
    logic expg;
    int last_acc, accepts;
    logic [31:0] held;

    tbl[0]  = '{1'b0, ADD, 32'd5,          32'd3,          1'b1, 32'h8,        4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, SUB, 32'd7,          32'd7,          1'b1, 32'h0,        4'b1000, 4'b1000, 1'b0};
    tbl[2]  = '{1'b1, AND, 32'hF0,         32'h0F,         1'b0, 32'h0,        4'b1000, 4'b1000, 1'b0};
    tbl[3]  = '{1'b0, ADD, 32'hFFFFFFFF,   32'd1,          1'b1, 32'h0,        4'b1100, 4'b1100, 1'b0};
    tbl[4]  = '{1'b1, ADC, 32'd1,          32'd1,          1'b1, 32'h3,        4'b0000, 4'b0000, 1'b1};
    tbl[5]  = '{1'b0, SBC, 32'd10,         32'd3,          1'b1, 32'h7,        4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{1'b1, MVN, 32'd0,          32'd0,          1'b1, 32'hFFFFFFFF, 4'b0010, 4'b0010, 1'b0};
    tbl[7]  = '{1'b0, EOR, 32'hFF,         32'h0F,         1'b0, 32'hF0,       4'b0000, 4'b0010, 1'b0};
    tbl[8]  = '{1'b1, ORR, 32'h80000000,   32'd1,          1'b1, 32'h80000001, 4'b0010, 4'b0010, 1'b0};
    tbl[9]  = '{1'b0, ADD, 32'h7FFFFFFF,   32'd1,          1'b1, 32'h80000000, 4'b0011, 4'b0011, 1'b0};
    tbl[10] = '{1'b1, MOV, 32'd0,          32'd7,          1'b0, 32'h7,        4'b0000, 4'b0011, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_sr_q", 32'(sr_q), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_sr", 32'(resp_sr), 32'd0);
    chk("rst_alu_val1", alu_val1, 32'd0);
    chk("rst_alu_c", 32'(alu_c), 32'd0);
    chk("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) do_op(tbl[i]);

    // Contention: both valid, fixed payloads, expect 0,1,0,1 every 3 cycles.
    do_reset();
    set_req(1'b0, 1'b1, ADD, 32'd100, 32'd1, 1'b0);
    set_req(1'b1, 1'b1, SUB, 32'd50,  32'd8, 1'b0);
    expg = 1'b0; last_acc = -1; accepts = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("cont_resp_id", 32'(resp1_valid), 32'(e.id));
          chk("cont_resp_result", resp_result, e.res);
        end else chk("cont_sb_empty", 32'd0, 32'd1);
      end
      if (req0_ready || req1_ready) begin
        chk("cont_grant", 32'(req1_ready), 32'(expg));
        if (last_acc >= 0) chk("cont_interval", 32'(c - last_acc), 32'd3);
        if (req1_ready) e = '{id: 1'b1, res: alu_f(SUB, 32'd50, 32'd8, 1'b0) >> 0, sr: 4'b0000};
        else            e = '{id: 1'b0, res: alu_f(ADD, 32'd100, 32'd1, 1'b0) >> 0, sr: 4'b0000};
        sb.push_back(e);
        expg = ~expg; last_acc = c; accepts++;
      end
    end
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("cont_accepts", 32'(accepts), 32'd4);
    chk("cont_sb_drained", 32'(sb.size()), 32'd0);

    // Back-pressure: resp0 stalled for 5 cycles while req1 waits.
    do_reset();
    set_req(1'b0, 1'b1, ADD, 32'd20, 32'd22, 1'b0);
    #1 chk("bp_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    resp0_ready = 1'b0;
    set_req(1'b1, 1'b1, MOV, 32'd0, 32'd9, 1'b0);
    @(posedge clk); #1;
    held = resp_result;
    chk("bp_result", held, 32'd42);
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp0_valid", 32'(resp0_valid), 32'd1);
      chk("bp_result_stable", resp_result, held);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp0_ready = 1'b1;
    #1 chk("bp_req1_ready_hold", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_req1_accept", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("bp_resp1_valid", 32'(resp1_valid), 32'd1);
    chk("bp_resp1_result", resp_result, 32'd9);
    @(posedge clk); #1;

    // Reset during EXEC.
    do_reset();
    set_req(1'b0, 1'b1, ADD, 32'd1, 32'd2, 1'b1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("rexec_busy", 32'(alu_val2), 32'd2);
    rst = 1'b1; #1;
    chk("rexec_alu_val1", alu_val1, 32'd0);
    chk("rexec_alu_cmd", 32'(alu_cmd), 32'd0);
    chk("rexec_resp_result", resp_result, 32'd0);
    chk("rexec_sr_q", 32'(sr_q), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rexec_no_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
      @(posedge clk); #1;
    end
    do_op(tbl[0]);

    // Reset during RESP.
    set_req(1'b1, 1'b1, SUB, 32'd7, 32'd7, 1'b1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("rresp_valid_before", 32'(resp1_valid), 32'd1);
    chk("rresp_srq_before", 32'(sr_q), 32'b1000);
    rst = 1'b1; #1;
    chk("rresp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
    chk("rresp_sr_q", 32'(sr_q), 32'd0);
    chk("rresp_resp_sr", 32'(resp_sr), 32'd0);
    chk("rresp_result", resp_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rresp_no_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
      @(posedge clk); #1;
    end
    do_op(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
